// File: rtl/power_pkg.sv
`default_nettype none
// ============================================================================
// Module      : power_pkg
// Description : Shared types and default timing constants for the power
//               switch sequencer (50 MHz system clock).
// Revision    : 1.0 - initial release
// ============================================================================
package power_pkg;

    // Debug encoding; FAULT and LATCHED share 2'b11.
    typedef enum logic [1:0] {
        ST_OFF   = 2'b00,
        ST_ARM   = 2'b01,
        ST_ON    = 2'b10,
        ST_FAULT = 2'b11
    } state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_ARM_CYCLES      = 16384;
    localparam int DEF_LOCKOUT_CYCLES  = 25000000;
    localparam int DEF_MAX_RETRIES     = 3;
    localparam int RETRY_W             = 4;

endpackage
`default_nettype wire

// File: rtl/power_switch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : power_switch_if
// Description : Switch/command/power-stage signal bundle of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface power_switch_if;
    import power_pkg::*;

    logic               sw_in;
    logic               cmd_on;
    logic               cmd_off;
    logic               kill_sw;
    logic               start;
    logic               power_good;
    logic               fault;
    logic [RETRY_W-1:0] retry_cnt;
    logic [1:0]         state;

    modport master (
        output sw_in, cmd_on, cmd_off, kill_sw,
        input  start, power_good, fault, retry_cnt, state
    );

    modport slave (
        input  sw_in, cmd_on, cmd_off, kill_sw,
        output start, power_good, fault, retry_cnt, state
    );

endinterface
`default_nettype wire

// File: rtl/switch_debounce.sv
`default_nettype none
// ============================================================================
// Module      : switch_debounce
// Description : 2-FF synchroniser plus stability debouncer with edge pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_in,
    output logic sw_db,
    output logic rise,
    output logic fall
);

    localparam int                CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync0;
    logic             r_sync1;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
            r_cnt   <= '0;
            sw_db   <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            r_sync0 <= sw_in;
            r_sync1 <= r_sync0;
            rise    <= 1'b0;
            fall    <= 1'b0;
            // Any cycle matching the accepted level restarts the stability window.
            if (r_sync1 == sw_db) begin
                r_cnt <= '0;
            end else if (r_cnt == c_last) begin
                r_cnt <= '0;
                sw_db <= r_sync1;
                rise  <= r_sync1;
                fall  <= ~r_sync1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/power_switch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : power_switch_ctrl
// Description : Switch/command sequencer driving power_management start, with
//               arm timeout, lockout timer and bounded automatic retries.
// Revision    : 1.0 - initial release
// ============================================================================
module power_switch_ctrl
    import power_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int ARM_CYCLES      = DEF_ARM_CYCLES,
    parameter int LOCKOUT_CYCLES  = DEF_LOCKOUT_CYCLES,
    parameter int MAX_RETRIES     = DEF_MAX_RETRIES
) (
    input  logic          clk,
    input  logic          reset_n,
    power_switch_if.slave bus
);

    // One timer serves both ARM and FAULT, sized for the longer interval.
    localparam int TMR_MAX = (ARM_CYCLES > LOCKOUT_CYCLES) ? ARM_CYCLES : LOCKOUT_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0]   c_arm_last    = TMR_W'(ARM_CYCLES - 1);
    localparam logic [TMR_W-1:0]   c_lock_last   = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0]   c_tmr_sat     = '1;
    localparam logic [RETRY_W-1:0] c_retry_limit = RETRY_W'(MAX_RETRIES);

    logic               r_rst_meta;
    logic               r_rst_sync_n;
    logic               w_rst_n;
    logic               w_sw_db;
    logic               w_db_rise;
    logic               w_db_fall;
    logic               w_req_on;
    logic               w_req_off;

    state_t             r_state;
    logic               r_latched;
    logic               r_start;
    logic               r_power_good;
    logic               r_fault;
    logic               r_src_cmd;
    logic [RETRY_W-1:0] r_retry_cnt;
    logic [TMR_W-1:0]   r_timer;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_meta   <= 1'b0;
            r_rst_sync_n <= 1'b0;
        end else begin
            r_rst_meta   <= 1'b1;
            r_rst_sync_n <= r_rst_meta;
        end
    end

    assign w_rst_n = r_rst_sync_n;

    switch_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .rst_n (w_rst_n),
        .sw_in (bus.sw_in),
        .sw_db (w_sw_db),
        .rise  (w_db_rise),
        .fall  (w_db_fall)
    );

    assign w_req_on  = w_db_rise | bus.cmd_on;
    assign w_req_off = w_db_fall | bus.cmd_off;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state      <= ST_OFF;
            r_latched    <= 1'b0;
            r_start      <= 1'b0;
            r_power_good <= 1'b0;
            r_fault      <= 1'b0;
            r_src_cmd    <= 1'b0;
            r_retry_cnt  <= '0;
            r_timer      <= '0;
        end else if (w_req_off) begin
            r_state      <= ST_OFF;
            r_latched    <= 1'b0;
            r_start      <= 1'b0;
            r_power_good <= 1'b0;
            r_fault      <= 1'b0;
            r_retry_cnt  <= '0;
            r_timer      <= '0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    r_retry_cnt <= '0;
                    if (w_req_on) begin
                        r_state   <= ST_ARM;
                        r_start   <= 1'b1;
                        r_timer   <= '0;
                        r_src_cmd <= bus.cmd_on;
                    end
                end
                ST_ARM: begin
                    if (bus.kill_sw) begin
                        r_state      <= ST_ON;
                        r_power_good <= 1'b1;
                        r_timer      <= '0;
                    end else if (r_timer == c_arm_last) begin
                        r_state <= ST_FAULT;
                        r_start <= 1'b0;
                        r_fault <= 1'b1;
                        r_timer <= '0;
                    end else if (r_timer != c_tmr_sat) begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_ON: begin
                    if (!bus.kill_sw) begin
                        r_state      <= ST_FAULT;
                        r_start      <= 1'b0;
                        r_power_good <= 1'b0;
                        r_fault      <= 1'b1;
                        r_timer      <= '0;
                    end
                end
                ST_FAULT: begin
                    // Once latched, only a power-off request gets us out.
                    if (!r_latched) begin
                        if (r_timer == c_lock_last) begin
                            r_timer <= '0;
                            if ((r_retry_cnt < c_retry_limit) && (w_sw_db || r_src_cmd)) begin
                                r_retry_cnt <= r_retry_cnt + 1'b1;
                                r_state     <= ST_ARM;
                                r_start     <= 1'b1;
                                r_fault     <= 1'b0;
                            end else begin
                                r_latched <= 1'b1;
                            end
                        end else if (r_timer != c_tmr_sat) begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_OFF;
            endcase
        end
    end

    assign bus.start      = r_start;
    assign bus.power_good = r_power_good;
    assign bus.fault      = r_fault;
    assign bus.retry_cnt  = r_retry_cnt;
    assign bus.state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_power_switch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_power_switch_ctrl
// Description : Directed scoreboard bench for power_switch_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_power_switch_ctrl;

    typedef struct {
        int         cyc;
        string      name;
        logic [8:0] val;   // {state, start, power_good, fault, retry_cnt}
    } exp_t;

    logic clk;
    logic reset_n;
    int   cyc;
    int   checks;
    int   failures;
    exp_t q[$];

    power_switch_if bus ();

    power_switch_ctrl #(
        .DEBOUNCE_CYCLES (8),
        .ARM_CYCLES      (32),
        .LOCKOUT_CYCLES  (16),
        .MAX_RETRIES     (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input int dly, input string nm, input logic [1:0] st,
                              input logic s, input logic pg, input logic f,
                              input logic [3:0] rc);
        exp_t e;
        int   idx;
        e.cyc  = cyc + dly;
        e.name = nm;
        e.val  = {st, s, pg, f, rc};
        idx    = q.size();
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].cyc > e.cyc) begin
                idx = i;
                break;
            end
        end
        q.insert(idx, e);
    endtask

    // Monitor: compares every queued expectation at the negedge of its cycle.
    initial begin
        exp_t       e;
        logic [8:0] act;
        checks   = 0;
        failures = 0;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e   = q.pop_front();
                act = {bus.state, bus.start, bus.power_good, bus.fault, bus.retry_cnt};
                checks++;
                if (e.cyc < cyc || act !== e.val) begin
                    failures++;
                    $display("FAIL %s cyc=%0d: got st=%b start=%b pg=%b fault=%b retry=%0d, want st=%b start=%b pg=%b fault=%b retry=%0d",
                             e.name, cyc, act[8:7], act[6], act[5], act[4], act[3:0],
                             e.val[8:7], e.val[6], e.val[5], e.val[4], e.val[3:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, pending=%0d", q.size());
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b0;
        bus.sw_in   = 1'b0;
        bus.cmd_on  = 1'b0;
        bus.cmd_off = 1'b0;
        bus.kill_sw = 1'b0;
        tick(2);
        expect_out(0, "reset", 2'b00, 0, 0, 0, 4'd0);
        tick(1);
        reset_n = 1'b1;
        tick(4);

        // Bouncing switch must never be accepted.
        for (int i = 0; i < 20; i++) begin
            bus.sw_in = ~bus.sw_in;
            for (int k = 0; k < 5; k++) expect_out(k, "db_bounce", 2'b00, 0, 0, 0, 4'd0);
            tick(5);
        end

        // Final edge: accepted after 2 sync + 8 stable + 1 FSM cycle, then
        // arm timeouts and retries with kill_sw held low.
        bus.sw_in = 1'b1;
        expect_out(10,  "db_pre",     2'b00, 0, 0, 0, 4'd0);
        expect_out(11,  "db_accept",  2'b01, 1, 0, 0, 4'd0);
        expect_out(42,  "arm_last",   2'b01, 1, 0, 0, 4'd0);
        expect_out(43,  "arm_tmo0",   2'b11, 0, 0, 1, 4'd0);
        expect_out(58,  "lock_last",  2'b11, 0, 0, 1, 4'd0);
        expect_out(59,  "retry1",     2'b01, 1, 0, 0, 4'd1);
        expect_out(91,  "arm_tmo1",   2'b11, 0, 0, 1, 4'd1);
        expect_out(107, "retry2",     2'b01, 1, 0, 0, 4'd2);
        expect_out(139, "arm_tmo2",   2'b11, 0, 0, 1, 4'd2);
        expect_out(155, "latch",      2'b11, 0, 0, 1, 4'd2);
        expect_out(170, "latch_hold", 2'b11, 0, 0, 1, 4'd2);
        tick(171);
        checks++;
        if (bus.fault !== 1'b1 || bus.start !== 1'b0) begin
            failures++;
            $display("FAIL latch_direct: fault=%b start=%b", bus.fault, bus.start);
        end

        bus.cmd_on = 1'b1;
        expect_out(1, "latch_cmd_on",  2'b11, 0, 0, 1, 4'd2);
        expect_out(2, "latch_cmd_on2", 2'b11, 0, 0, 1, 4'd2);
        tick(1);
        bus.cmd_on = 1'b0;
        tick(1);
        bus.cmd_off = 1'b1;
        expect_out(1, "latch_clear", 2'b00, 0, 0, 0, 4'd0);
        tick(1);
        bus.cmd_off = 1'b0;
        bus.sw_in   = 1'b0;
        expect_out(14, "sw_off", 2'b00, 0, 0, 0, 4'd0);
        tick(15);

        // Normal command on/off.
        bus.cmd_on = 1'b1;
        expect_out(1, "cmd_arm", 2'b01, 1, 0, 0, 4'd0);
        tick(1);
        bus.cmd_on = 1'b0;
        tick(9);
        bus.kill_sw = 1'b1;
        expect_out(0, "arm_wait", 2'b01, 1, 0, 0, 4'd0);
        expect_out(1, "on",       2'b10, 1, 1, 0, 4'd0);
        tick(3);
        checks++;
        if (bus.power_good !== 1'b1) begin
            failures++;
            $display("FAIL on_direct: power_good=%b", bus.power_good);
        end
        bus.cmd_off = 1'b1;
        expect_out(1, "cmd_off", 2'b00, 0, 0, 0, 4'd0);
        tick(1);
        bus.cmd_off = 1'b0;
        bus.kill_sw = 1'b0;
        tick(2);

        // Drop-out in ON and automatic retry on a command-sourced request.
        bus.kill_sw = 1'b1;
        bus.cmd_on  = 1'b1;
        expect_out(1, "t4_arm", 2'b01, 1, 0, 0, 4'd0);
        expect_out(2, "t4_on",  2'b10, 1, 1, 0, 4'd0);
        tick(1);
        bus.cmd_on = 1'b0;
        tick(3);
        bus.kill_sw = 1'b0;
        expect_out(1, "dropout", 2'b11, 0, 0, 1, 4'd0);
        tick(1);
        bus.kill_sw = 1'b1;
        expect_out(15, "drop_lock",  2'b11, 0, 0, 1, 4'd0);
        expect_out(16, "drop_retry", 2'b01, 1, 0, 0, 4'd1);
        expect_out(17, "drop_on",    2'b10, 1, 1, 0, 4'd1);
        tick(18);

        // Simultaneous on/off: off wins in ON and in OFF.
        bus.cmd_on  = 1'b1;
        bus.cmd_off = 1'b1;
        expect_out(1, "pair_in_on", 2'b00, 0, 0, 0, 4'd0);
        tick(1);
        expect_out(1, "pair_in_off",  2'b00, 0, 0, 0, 4'd0);
        expect_out(2, "pair_in_off2", 2'b00, 0, 0, 0, 4'd0);
        tick(1);
        bus.cmd_on  = 1'b0;
        bus.cmd_off = 1'b0;
        bus.kill_sw = 1'b0;
        tick(2);

        // Asynchronous reset mid-ARM, checked before the next rising edge.
        bus.cmd_on = 1'b1;
        expect_out(1, "t6_arm", 2'b01, 1, 0, 0, 4'd0);
        tick(1);
        bus.cmd_on = 1'b0;
        tick(3);
        expect_out(0, "async_rst", 2'b00, 0, 0, 0, 4'd0);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.start !== 1'b0) begin
            failures++;
            $display("FAIL async_direct: start=%b", bus.start);
        end
        tick(3);
        reset_n = 1'b1;
        tick(4);
        expect_out(0, "post_rst", 2'b00, 0, 0, 0, 4'd0);
        checks++;
        if ({bus.state, bus.start, bus.power_good, bus.fault, bus.retry_cnt} !== 9'd0) begin
            failures++;
            $display("FAIL post_rst_direct: st=%b start=%b pg=%b fault=%b retry=%0d",
                     bus.state, bus.start, bus.power_good, bus.fault, bus.retry_cnt);
        end
        tick(1);

        for (int i = 0; i < 20 && q.size() > 0; i++) tick(1);
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            failures++;
            $display("FAIL %s: expectation never compared (cycle %0d, now %0d)", e.name, e.cyc, cyc);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
